srl_delay_arbiter: RTL and testbench

//  Shares one fixed-latency shift_reg delay line (DATA_WIDTH x SRL_DEPTH) between
//  NUM_REQ requesters. Round-robin arbitration with per-requester credit flow control.

---
 rtl/srl_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/shift_reg.sv | 23 ++
 rtl/srl_delay_arbiter.sv | 148 ++++++++++++++
 tb/tb_srl_delay_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srl_arb_pkg.sv
// Shared types for the SRL delay arbiter: requester ID width and the sideband tag
// that travels alongside each payload through the delay line.
package srl_arb_pkg;

   localparam int MAX_REQ = 4;
   localparam int ID_W    = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over an eligibility vector; the pointer register
// moves past the winner so the next search starts one above the last grant.
module rr_arbiter
   import srl_arb_pkg::*;
#(
   parameter int NUM_REQ = MAX_REQ
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_elig,
   output logic [NUM_REQ-1:0] o_grant,
   output req_id_t            o_grant_id
);

   localparam req_id_t LAST_ID = req_id_t'(NUM_REQ - 1);

   req_id_t ptr;

   always_comb begin
      int      idx;
      req_id_t cand;
      logic    found;
      o_grant    = '0;
      o_grant_id = '0;
      found      = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         cand = req_id_t'(idx);
         if (!found && i_elig[cand]) begin
            found         = 1'b1;
            o_grant[cand] = 1'b1;
            o_grant_id    = cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr <= '0;
      end else if (|o_grant) begin
         ptr <= (o_grant_id == LAST_ID) ? '0 : req_id_t'(o_grant_id + 1'b1);
      end
   end

endmodule

// File: rtl/shift_reg.sv
// Fixed-latency data delay line, DEPTH cycles from input to output.
// Always shifts, no reset, no flow control: validity is tracked outside.
module shift_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge i_clk) begin
      stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
         stage[i] <= stage[i-1];
      end
   end

   assign o_data = stage[DEPTH-1];

endmodule

// File: rtl/srl_delay_arbiter.sv
// Shares one SRL_DEPTH-cycle delay line among NUM_REQ requesters, tagging words with their ID.
// A requester is only granted while it holds a credit; returns above CREDITS are flagged sticky.
module srl_delay_arbiter
   import srl_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SRL_DEPTH  = 16,
   parameter int NUM_REQ    = MAX_REQ,
   parameter int CREDITS    = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]              o_req_ready,
   output logic [NUM_REQ-1:0]              o_rsp_valid,
   output logic [DATA_WIDTH-1:0]           o_rsp_data,
   input  logic [NUM_REQ-1:0]              i_rsp_credit,
   output logic [$clog2(SRL_DEPTH+1)-1:0]  o_inflight,
   output logic                            o_credit_err
);

   localparam int              CW        = $clog2(CREDITS + 1);
   localparam int              IW        = $clog2(SRL_DEPTH + 1);
   localparam logic [CW-1:0]   CRED_FULL = CW'(CREDITS);

   logic                   running;
   logic [NUM_REQ-1:0]     elig;
   logic [NUM_REQ-1:0]     grant;
   req_id_t                grant_id;
   logic                   accept;
   logic                   rsp_any;
   logic [NUM_REQ-1:0]     overflow;
   logic [CW-1:0]          credit [NUM_REQ];
   logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];
   logic [DATA_WIDTH-1:0]  srl_in;
   logic [DATA_WIDTH-1:0]  srl_out;
   tag_t                   tag_pipe [SRL_DEPTH];
   tag_t                   tag_tail;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [IW-1:0]          inflight;
   logic                   credit_err;

   // Holds grants off while in reset and for the first cycle after release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         running <= 1'b0;
      end else begin
         running <= 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
         elig[k]     = running && i_req_valid[k] && (credit[k] != '0);
         overflow[k] = i_rsp_credit[k] && !grant[k] && (credit[k] == CRED_FULL);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_elig     (elig),
      .o_grant    (grant),
      .o_grant_id (grant_id)
   );

   assign accept = |grant;
   assign srl_in = req_data[grant_id];

   shift_reg #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (SRL_DEPTH)
   ) u_srl (
      .i_clk  (i_clk),
      .i_data (srl_in),
      .o_data (srl_out)
   );

   // Sideband runs in lockstep with the SRL; idle cycles shift in a zero valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SRL_DEPTH; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{vld: accept, id: grant_id};
         for (int i = 1; i < SRL_DEPTH; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign tag_tail = tag_pipe[SRL_DEPTH-1];

   always_comb begin
      rsp_valid = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (tag_tail.vld && (tag_tail.id == req_id_t'(k))) begin
            rsp_valid[k] = 1'b1;
         end
      end
   end

   assign rsp_any = tag_tail.vld;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            credit[k] <= CRED_FULL;
         end
         credit_err <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k] && !i_rsp_credit[k]) begin
               credit[k] <= credit[k] - 1'b1;
            end else if (!grant[k] && i_rsp_credit[k] && (credit[k] != CRED_FULL)) begin
               credit[k] <= credit[k] + 1'b1;
            end
         end
         if (|overflow) begin
            credit_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight <= '0;
      end else begin
         case ({accept, rsp_any})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   assign o_req_ready  = grant;
   assign o_rsp_valid  = rsp_valid;
   assign o_rsp_data   = srl_out;
   assign o_inflight   = inflight;
   assign o_credit_err = credit_err;

endmodule

// File: tb/tb_srl_delay_arbiter.sv
// Directed and table-driven checks of the shared delay-line arbiter, plus a
// random run against a small reference model and scoreboard.
module tb_srl_delay_arbiter;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int NR    = 4;
   localparam int CR    = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [NR-1:0]   rsp_credit;
   logic [4:0]      inflight;
   logic            credit_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   srl_delay_arbiter #(
      .DATA_WIDTH (DW),
      .SRL_DEPTH  (DEPTH),
      .NUM_REQ    (NR),
      .CREDITS    (CR)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_data   (req_data),
      .o_req_ready  (req_ready),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_data   (rsp_data),
      .i_rsp_credit (rsp_credit),
      .o_inflight   (inflight),
      .o_credit_err (credit_err)
   );

   typedef struct {
      logic [3:0] valid;
      logic [3:0] ready;
      logic [3:0] rsp;
      logic [7:0] data;
      logic [4:0] inf;
   } vec_t;

   typedef struct {
      int         id;
      logic [7:0] data;
      int         cyc;
   } sb_t;

   vec_t tbl [26];
   sb_t  q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic set_data(input int idx);
      for (int k = 0; k < NR; k++) begin
         req_data[k*DW +: DW] = {4'(idx), 4'(k)};
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      req_valid  = '0;
      rsp_credit = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_acc;
      int seen;
      int cred [NR];
      int pend [NR];
      int ptr;
      int gid;
      int kk;
      logic [NR-1:0] exp_g;
      logic [NR-1:0] exp_rsp;

      tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 5'd0};
      tbl[1]  = '{4'b1111, 4'b0001, 4'b0000, 8'h00, 5'd0};
      tbl[2]  = '{4'b1111, 4'b0010, 4'b0000, 8'h00, 5'd1};
      tbl[3]  = '{4'b1001, 4'b1000, 4'b0000, 8'h00, 5'd2};
      tbl[4]  = '{4'b0110, 4'b0010, 4'b0000, 8'h00, 5'd3};
      tbl[5]  = '{4'b0001, 4'b0001, 4'b0000, 8'h00, 5'd4};
      tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 5'd5};
      tbl[7]  = '{4'b1101, 4'b0100, 4'b0000, 8'h00, 5'd5};
      tbl[8]  = '{4'b1011, 4'b1000, 4'b0000, 8'h00, 5'd6};
      for (int i = 9; i <= 16; i++) tbl[i] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 5'd7};
      tbl[17] = '{4'b0000, 4'b0000, 4'b0001, 8'h10, 5'd7};
      tbl[18] = '{4'b0000, 4'b0000, 4'b0010, 8'h21, 5'd6};
      tbl[19] = '{4'b0000, 4'b0000, 4'b1000, 8'h33, 5'd5};
      tbl[20] = '{4'b0000, 4'b0000, 4'b0010, 8'h41, 5'd4};
      tbl[21] = '{4'b0000, 4'b0000, 4'b0001, 8'h50, 5'd3};
      tbl[22] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 5'd2};
      tbl[23] = '{4'b0000, 4'b0000, 4'b0100, 8'h72, 5'd2};
      tbl[24] = '{4'b0000, 4'b0000, 4'b1000, 8'h83, 5'd1};
      tbl[25] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 5'd0};

      // Reset state, with requests already pending.
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_data   = '0;
      rsp_credit = '0;
      repeat (2) @(posedge clk);
      #5;
      check("reset_ready", 32'(req_ready), 32'(0));
      check("reset_rsp", 32'(rsp_valid), 32'(0));
      check("reset_inflight", 32'(inflight), 32'(0));
      check("reset_err", 32'(credit_err), 32'(0));

      // Arbitration order, latency and data return.
      do_reset();
      for (int i = 0; i < 26; i++) begin
         tick();
         req_valid  = tbl[i].valid;
         rsp_credit = '0;
         set_data(i);
         settle();
         check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
         check($sformatf("tbl%0d_rsp", i), 32'(rsp_valid), 32'(tbl[i].rsp));
         check($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(tbl[i].inf));
         if (tbl[i].rsp != 4'b0000) begin
            check($sformatf("tbl%0d_data", i), 32'(rsp_data), 32'(tbl[i].data));
         end
      end

      // Single word from requester 1.
      do_reset();
      tick();
      req_valid = 4'b0010;
      req_data  = '0;
      req_data[1*DW +: DW] = 8'hA5;
      settle();
      check("single_ready", 32'(req_ready), 32'(4'b0010));
      seen = 0;
      for (int j = 1; j <= 17; j++) begin
         tick();
         req_valid = '0;
         settle();
         if (j < 16 && rsp_valid != '0) seen++;
         if (j == 1) check("single_inflight_first", 32'(inflight), 32'(1));
         if (j == 16) begin
            check("single_rsp", 32'(rsp_valid), 32'(4'b0010));
            check("single_data", 32'(rsp_data), 32'(8'hA5));
            check("single_inflight_last", 32'(inflight), 32'(1));
         end
         if (j == 17) begin
            check("single_rsp_after", 32'(rsp_valid), 32'(0));
            check("single_inflight_done", 32'(inflight), 32'(0));
         end
      end
      check("single_early_rsp", 32'(seen), 32'(0));

      // All requesters streaming with credits returned on every response.
      do_reset();
      for (int c = 0; c < 48; c++) begin
         tick();
         req_valid  = 4'b1111;
         rsp_credit = rsp_valid;
         set_data(c);
         settle();
         check($sformatf("stream%0d_ready", c), 32'(req_ready), 32'(1 << (c % NR)));
         if (c >= DEPTH) begin
            check($sformatf("stream%0d_rsp", c), 32'(rsp_valid), 32'(1 << ((c - DEPTH) % NR)));
            check($sformatf("stream%0d_data", c), 32'(rsp_data),
                  32'({4'(c - DEPTH), 4'((c - DEPTH) % NR)}));
         end else begin
            check($sformatf("stream%0d_rsp", c), 32'(rsp_valid), 32'(0));
         end
      end

      // Credit exhaustion on requester 0, then a single return.
      do_reset();
      n_acc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         req_valid = 4'b0001;
         settle();
         if (req_ready[0]) n_acc++;
      end
      check("exhaust_accepts", 32'(n_acc), 32'(CR));
      check("exhaust_ready", 32'(req_ready), 32'(0));
      n_acc = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         rsp_credit = (c == 0) ? 4'b0001 : 4'b0000;
         settle();
         if (req_ready[0]) n_acc++;
      end
      check("exhaust_one_more", 32'(n_acc), 32'(1));
      check("exhaust_err", 32'(credit_err), 32'(0));

      // Grant and credit return in the same cycle on requester 2.
      do_reset();
      tick();
      req_valid  = 4'b0100;
      rsp_credit = 4'b0100;
      settle();
      check("simul_ready", 32'(req_ready), 32'(4'b0100));
      n_acc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         rsp_credit = '0;
         settle();
         if (c == 0) check("simul_err", 32'(credit_err), 32'(0));
         if (req_ready[2]) n_acc++;
      end
      check("simul_accepts", 32'(n_acc), 32'(CR));

      // Return with a full counter sets the sticky error.
      do_reset();
      tick();
      rsp_credit = 4'b0100;
      settle();
      check("err_before", 32'(credit_err), 32'(0));
      tick();
      rsp_credit = '0;
      settle();
      check("err_set", 32'(credit_err), 32'(1));
      for (int c = 0; c < 6; c++) begin
         tick();
         req_valid = 4'b1111;
         settle();
      end
      check("err_sticky", 32'(credit_err), 32'(1));
      do_reset();
      tick();
      settle();
      check("err_cleared", 32'(credit_err), 32'(0));

      // Reset with five words in flight.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         req_valid = 4'b1111;
         set_data(c);
         settle();
      end
      tick();
      req_valid = '0;
      settle();
      check("midrst_inflight_before", 32'(inflight), 32'(5));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         req_valid = '0;
         settle();
         if (rsp_valid != '0) seen++;
      end
      check("midrst_no_rsp", 32'(seen), 32'(0));
      check("midrst_inflight", 32'(inflight), 32'(0));
      tick();
      req_valid = 4'b1111;
      settle();
      check("midrst_ptr", 32'(req_ready), 32'(4'b0001));
      n_acc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         req_valid = 4'b0001;
         settle();
         if (req_ready[0]) n_acc++;
      end
      check("midrst_credits", 32'(n_acc), 32'(CR - 1));

      // Random traffic against a reference model and scoreboard.
      do_reset();
      for (int k = 0; k < NR; k++) begin
         cred[k] = CR;
         pend[k] = 0;
      end
      ptr = 0;
      q.delete();
      for (int c = 0; c < 4000; c++) begin
         tick();
         req_valid = 4'($urandom);
         req_data  = 32'($urandom);
         for (int k = 0; k < NR; k++) begin
            rsp_credit[k] = (pend[k] > 0) && ($urandom_range(0, 7) == 0);
         end
         settle();
         gid = -1;
         for (int i = 0; i < NR; i++) begin
            kk = (ptr + i) % NR;
            if (gid < 0 && req_valid[kk] && cred[kk] > 0) gid = kk;
         end
         exp_g = '0;
         if (gid >= 0) exp_g[gid] = 1'b1;
         check($sformatf("rand%0d_ready", c), 32'(req_ready), 32'(exp_g));
         check($sformatf("rand%0d_inflight", c), 32'(inflight), 32'(q.size()));
         exp_rsp = '0;
         if (q.size() > 0 && q[0].cyc + DEPTH == c) begin
            exp_rsp[q[0].id] = 1'b1;
            check($sformatf("rand%0d_data", c), 32'(rsp_data), 32'(q[0].data));
         end
         check($sformatf("rand%0d_rsp", c), 32'(rsp_valid), 32'(exp_rsp));
         if (exp_rsp != '0) begin
            pend[q[0].id]++;
            void'(q.pop_front());
         end
         if (gid >= 0) begin
            q.push_back('{gid, req_data[gid*DW +: DW], c});
            cred[gid]--;
            ptr = (gid + 1) % NR;
         end
         for (int k = 0; k < NR; k++) begin
            if (rsp_credit[k]) begin
               pend[k]--;
               cred[k]++;
            end
         end
      end
      check("rand_err", 32'(credit_err), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
